// File: rtl/program_loader.sv
// program_loader: boot-time loader in front of the core. Holds the core in
// reset, presets every BHT entry, then streams program words into
// instruction RAM as big-endian bytes before releasing the core.
module program_loader #(
  parameter int         IMEM_BYTES    = 1024,
  parameter int         ADDR_W        = 10,
  parameter int         BHT_ENTRIES   = 16,
  parameter int         BHT_IDX_W     = 4,
  parameter logic [1:0] BHT_INIT_VAL  = 2'b01,
  parameter int         RELEASE_DELAY = 3
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          in_data_i,
  input  logic                 in_last_i,
  input  logic                 restart_i,
  output logic                 imem_we_o,
  output logic [ADDR_W-1:0]    imem_addr_o,
  output logic [7:0]           imem_wdata_o,
  output logic                 bht_we_o,
  output logic [BHT_IDX_W-1:0] bht_idx_o,
  output logic [1:0]           bht_wdata_o,
  output logic                 core_reset_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [ADDR_W-2:0]    word_count_o
);

  localparam int                WC_W      = ADDR_W - 1;
  localparam logic [WC_W-1:0]   WORDS     = WC_W'(IMEM_BYTES / 4);
  localparam int                BC_W      = BHT_IDX_W + 1;
  localparam logic [BC_W-1:0]   BHT_END   = BC_W'(BHT_ENTRIES);
  localparam int                HC_W      = $clog2(RELEASE_DELAY + 1);
  localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(RELEASE_DELAY - 1);

  // WRk names the state in which byte k is on the RAM write port.
  typedef enum logic [2:0] {
    S_BHT, S_WAIT, S_WR0, S_WR1, S_WR2, S_WR3, S_HOLD, S_RUN
  } state_t;

  state_t                 state_q;
  logic [BC_W-1:0]        bht_cnt_q;
  logic [WC_W-1:0]        wc_q;
  logic [HC_W-1:0]        hold_cnt_q;
  logic [31:0]            word_q;     // remaining bytes, next one in [31:24]
  logic                   last_q;
  logic                   in_ready_q;
  logic                   imem_we_q;
  logic [ADDR_W-1:0]      imem_addr_q;
  logic [7:0]             imem_wdata_q;
  logic                   bht_we_q;
  logic [BHT_IDX_W-1:0]   bht_idx_q;
  logic [1:0]             bht_wdata_q;
  logic                   core_reset_q;
  logic                   done_q;
  logic                   error_q;

  // Load sequencer; every output is a flop updated together with the state.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q      <= S_BHT;
      bht_cnt_q    <= '0;
      wc_q         <= '0;
      hold_cnt_q   <= '0;
      word_q       <= '0;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      bht_we_q     <= 1'b0;
      bht_idx_q    <= '0;
      bht_wdata_q  <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        S_BHT: begin
          if (bht_cnt_q == BHT_END) begin
            bht_we_q    <= 1'b0;
            bht_wdata_q <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= S_WAIT;
          end else begin
            bht_we_q    <= 1'b1;
            bht_idx_q   <= bht_cnt_q[BHT_IDX_W-1:0];
            bht_wdata_q <= BHT_INIT_VAL;
            bht_cnt_q   <= bht_cnt_q + BC_W'(1);
          end
        end
        S_WAIT: begin
          // in_ready_q is high throughout this state
          if (in_valid_i) begin
            in_ready_q   <= 1'b0;
            last_q       <= in_last_i;
            word_q       <= {in_data_i[23:0], 8'h00};
            imem_we_q    <= 1'b1;
            imem_addr_q  <= {wc_q[WC_W-2:0], 2'd0};
            imem_wdata_q <= in_data_i[31:24];
            state_q      <= S_WR0;
          end
        end
        S_WR0, S_WR1, S_WR2: begin
          imem_addr_q  <= imem_addr_q + ADDR_W'(1);
          imem_wdata_q <= word_q[31:24];
          word_q       <= {word_q[23:0], 8'h00};
          state_q      <= (state_q == S_WR0) ? S_WR1 :
                          (state_q == S_WR1) ? S_WR2 : S_WR3;
        end
        S_WR3: begin
          imem_we_q    <= 1'b0;
          imem_addr_q  <= '0;
          imem_wdata_q <= '0;
          wc_q         <= wc_q + WC_W'(1);
          if (last_q || (wc_q + WC_W'(1) == WORDS)) begin
            // a word that fills RAM exactly is fine when it is the last one
            error_q    <= ~last_q;
            hold_cnt_q <= '0;
            state_q    <= S_HOLD;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            core_reset_q <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= S_RUN;
          end else begin
            hold_cnt_q <= hold_cnt_q + HC_W'(1);
          end
        end
        S_RUN: begin
          if (restart_i) begin
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            wc_q         <= '0;
            bht_cnt_q    <= '0;
            state_q      <= S_BHT;
          end
        end
        default: state_q <= S_BHT;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign bht_we_o     = bht_we_q;
  assign bht_idx_o    = bht_idx_q;
  assign bht_wdata_o  = bht_wdata_q;
  assign core_reset_o = core_reset_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign word_count_o = wc_q;

endmodule
